// File: rtl/mc_defs.sv
// Shared encodings for the MulCPU multicycle control unit.
package mc_defs;

  typedef enum logic [2:0] {
    S_IF     = 3'b000,
    S_ID     = 3'b001,
    S_EXE_LS = 3'b010,
    S_MEM    = 3'b011,
    S_WB_LD  = 3'b100,
    S_EXE_BR = 3'b101,
    S_EXE_AL = 3'b110,
    S_WB_AL  = 3'b111
  } state_t;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_REG    = 2'b10;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [1:0] RD_R31 = 2'b00;
  localparam logic [1:0] RD_RT  = 2'b01;
  localparam logic [1:0] RD_RD  = 2'b10;

  // True for opcodes that take the EXE_AL/WB_AL path.
  function automatic logic is_alu_op(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_ADDI, OP_OR, OP_AND, OP_ORI, OP_SLL, OP_SLT: is_alu_op = 1'b1;
      default: is_alu_op = 1'b0;
    endcase
  endfunction

  // ALU operation for an arithmetic/logic opcode.
  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OP_SUB:         alu_op_of = ALU_SUB;
      OP_OR, OP_ORI:  alu_op_of = ALU_OR;
      OP_AND:         alu_op_of = ALU_AND;
      OP_SLL:         alu_op_of = ALU_SLL;
      OP_SLT:         alu_op_of = ALU_SLT;
      default:        alu_op_of = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational decode of (state, opcode, zero) into datapath controls.
module mc_output_decode
  import mc_defs::*;
#(
  parameter int OPW = 6
) (
  input  state_t         st,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           pcwre,
  output logic [1:0]     pcsrc,
  output logic           irwre,
  output logic           insmemrw,
  output logic           extsel,
  output logic           alusrca,
  output logic           alusrcb,
  output logic [2:0]     aluop,
  output logic           regwre,
  output logic [1:0]     regdst,
  output logic           wrregdata,
  output logic           dbdatasrc,
  output logic           mrd,
  output logic           mwr
);

  logic is_imm;
  assign is_imm = (opcode == OP_ADDI) || (opcode == OP_ORI);

  // Per-state control outputs; every output defaulted before the case.
  always_comb begin
    pcwre     = 1'b0;
    pcsrc     = PC_NEXT;
    irwre     = 1'b0;
    insmemrw  = 1'b0;
    extsel    = 1'b0;
    alusrca   = 1'b0;
    alusrcb   = 1'b0;
    aluop     = ALU_ADD;
    regwre    = 1'b0;
    regdst    = RD_RT;
    wrregdata = 1'b0;
    dbdatasrc = 1'b0;
    mrd       = 1'b0;
    mwr       = 1'b0;
    case (st)
      S_IF: begin
        insmemrw = 1'b1;
        irwre    = 1'b1;
      end
      S_ID: begin
        case (opcode)
          OP_J: begin
            pcwre = 1'b1;
            pcsrc = PC_JUMP;
          end
          OP_JR: begin
            pcwre = 1'b1;
            pcsrc = PC_REG;
          end
          OP_JAL: begin
            pcwre     = 1'b1;
            pcsrc     = PC_JUMP;
            regwre    = 1'b1;
            regdst    = RD_R31;
            wrregdata = 1'b0;
          end
          // halt keeps the PC frozen so the same word is refetched
          OP_HALT, OP_BEQ, OP_LW, OP_SW: ;
          default: pcwre = !is_alu_op(opcode);
        endcase
      end
      S_EXE_AL, S_WB_AL: begin
        aluop   = alu_op_of(opcode);
        alusrcb = is_imm;
        extsel  = (opcode == OP_ADDI);
        alusrca = (opcode == OP_SLL);
        regdst  = is_imm ? RD_RT : RD_RD;
        if (st == S_WB_AL) begin
          regwre    = 1'b1;
          wrregdata = 1'b1;
          pcwre     = 1'b1;
        end
      end
      S_EXE_BR: begin
        aluop  = ALU_SUB;
        extsel = 1'b1;
        pcwre  = 1'b1;
        pcsrc  = zero ? PC_BRANCH : PC_NEXT;
      end
      S_EXE_LS, S_MEM: begin
        alusrcb = 1'b1;
        extsel  = 1'b1;
        if (st == S_MEM) begin
          if (opcode == OP_SW) begin
            mwr   = 1'b1;
            pcwre = 1'b1;
          end else begin
            mrd = 1'b1;
          end
        end
      end
      S_WB_LD: begin
        mrd       = 1'b1;
        regwre    = 1'b1;
        wrregdata = 1'b1;
        dbdatasrc = 1'b1;
        pcwre     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM for MulCPU: state register, retired counter, output decode.
//
// state  | meaning
// IF     | fetch instruction into IR
// ID     | decode; jumps, nop and halt finish here
// EXE_LS | address calculation for lw/sw
// MEM    | data memory access (sw finishes here)
// WB_LD  | write loaded data to register file
// EXE_BR | beq compare and branch
// EXE_AL | arithmetic/logic execute
// WB_AL  | write ALU result to register file
module mc_control_unit
  import mc_defs::*;
#(
  parameter int OPW  = 6,
  parameter int CNTW = 32
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic [OPW-1:0]  opcode,
  input  logic            zero,
  output logic            PCWre,
  output logic [1:0]      PCsrc,
  output logic            IRWre,
  output logic            InsMemRW,
  output logic            ExtSel,
  output logic            ALUSrcA,
  output logic            ALUSrcB,
  output logic [2:0]      ALUOp,
  output logic            RegWre,
  output logic [1:0]      RegDst,
  output logic            WrRegData,
  output logic            DBDataSrc,
  output logic            mRD,
  output logic            mWR,
  output logic [2:0]      state,
  output logic [CNTW-1:0] retired
);

  state_t state_q, state_d;
  logic   pcwre_dec, regwre_dec, mwr_dec;

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:     state_d = S_ID;
      S_ID: begin
        if (opcode == OP_BEQ)                         state_d = S_EXE_BR;
        else if (opcode == OP_LW || opcode == OP_SW)  state_d = S_EXE_LS;
        else if (is_alu_op(opcode))                   state_d = S_EXE_AL;
        else                                          state_d = S_IF;
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_EXE_LS: state_d = S_MEM;
      S_MEM:    state_d = (opcode == OP_LW) ? S_WB_LD : S_IF;
      default:  state_d = S_IF;
    endcase
  end

  // Retired-instruction counter; one count per PC update, halt never counts.
  always_ff @(posedge CLK) begin
    if (Reset)      retired <= '0;
    else if (PCWre) retired <= retired + CNTW'(1);
  end

  mc_output_decode #(.OPW(OPW)) u_decode (
    .st        (state_q),
    .opcode    (opcode),
    .zero      (zero),
    .pcwre     (pcwre_dec),
    .pcsrc     (PCsrc),
    .irwre     (IRWre),
    .insmemrw  (InsMemRW),
    .extsel    (ExtSel),
    .alusrca   (ALUSrcA),
    .alusrcb   (ALUSrcB),
    .aluop     (ALUOp),
    .regwre    (regwre_dec),
    .regdst    (RegDst),
    .wrregdata (WrRegData),
    .dbdatasrc (DBDataSrc),
    .mrd       (mRD),
    .mwr       (mwr_dec)
  );

  // A reset landing mid-instruction must not commit anything on that edge.
  assign PCWre  = pcwre_dec  & ~Reset;
  assign RegWre = regwre_dec & ~Reset;
  assign mWR    = mwr_dec    & ~Reset;
  assign state  = state_q;

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Multicycle control FSM for MulCPU: the producer end of the next-PC path.
- Drives PCsrc and PCWre into the next-PC selector and PC register.
- Steps each instruction through IF/ID/EXE/MEM/WB.
- Emits all datapath write enables and selects, plus a retired-instruction counter for debug.

Parameters:
- OPW, 6, opcode width.
- CNTW, 32, width of retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- opcode  in  OPW  IR[31:26], valid from ID onward.
- zero  in  1  ALU zero flag, sampled in EXE_BR.
- PCWre  out  1  PC register load enable.
- PCsrc  out  2  next-PC select:
  - 00 = PC+4
  - 01 = PC+4+(ext<<2)
  - 10 = rs value
  - 11 = jump target
- IRWre  out  1  instruction register load.
- InsMemRW  out  1  instruction memory read enable.
- ExtSel  out  1  1 = sign extend, 0 = zero extend.
- ALUSrcA  out  1  1 = shamt, 0 = rs.
- ALUSrcB  out  1  1 = extended immediate, 0 = rt.
- ALUOp  out  3  000 add, 001 sub, 010 or, 011 and, 100 sll, 101 slt.
- RegWre  out  1  register file write enable.
- RegDst  out  2  00 = $31, 01 = rt, 10 = rd.
- WrRegData  out  1  0 = PC+4, 1 = ALU/memory result.
- DBDataSrc  out  1  0 = ALU result, 1 = memory data.
- mRD  out  1  data memory read.
- mWR  out  1  data memory write.
- state  out  3  current state, for debug.
- retired  out  CNTW  count of completed instructions.

Behaviour:
- State encoding:
  - IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111.
- Opcodes:
  - add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110.
  - sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
  - Any other opcode is treated as a nop.
- Transitions (on rising edge of CLK):
  - IF -> ID.
  - ID -> IF for j, jr, jal, halt, nop.
  - ID -> EXE_BR for beq.
  - ID -> EXE_LS for lw/sw.
  - ID -> EXE_AL for arithmetic/logic ops.
  - EXE_AL -> WB_AL -> IF.
  - EXE_BR -> IF.
  - EXE_LS -> MEM.
  - MEM -> IF for sw; MEM -> WB_LD for lw.
  - WB_LD -> IF.
- Outputs are combinational from the registered state, opcode and zero. The only sequential elements are the state register and the retired counter.
- Outputs default to 0, PCsrc=00, RegDst=01, except as listed below.
- IF: InsMemRW=1, IRWre=1.
- ID:
  - j: PCWre=1, PCsrc=11.
  - jr: PCWre=1, PCsrc=10.
  - jal: PCWre=1, PCsrc=11, RegWre=1, RegDst=00, WrRegData=0.
  - nop: PCWre=1, PCsrc=00.
  - halt: PCWre=0. The PC freezes and the halt instruction is refetched forever until Reset.
- EXE_AL / WB_AL:
  - ALUOp comes from the opcode.
  - ALUSrcB=1 for addi/ori; ExtSel=1 for addi, 0 for ori.
  - ALUSrcA=1 for sll.
  - WB_AL: RegWre=1, WrRegData=1, DBDataSrc=0, PCWre=1, PCsrc=00.
  - RegDst=01 for immediate ops, 10 otherwise.
- EXE_BR: ALUOp=001, ExtSel=1, PCWre=1, PCsrc = zero ? 01 : 00.
- EXE_LS and MEM: ALUSrcB=1, ExtSel=1, ALUOp=000.
  - MEM, sw: mWR=1, PCWre=1, PCsrc=00.
  - MEM, lw: mRD=1.
- WB_LD: mRD=1, RegWre=1, RegDst=01, WrRegData=1, DBDataSrc=1, PCWre=1, PCsrc=00.
- Retired counter:
  - Increments on each edge where PCWre=1.
  - Wraps modulo 2^CNTW.
  - Halt does not increment it.
- Reset (synchronous, active-high):
  - state <= IF, retired <= 0.
  - Outputs therefore take IF values in the cycle after reset is sampled.
  - Reset asserted mid-instruction aborts it. No PCWre, RegWre or mWR pulse occurs on the reset edge.
- PCWre is exactly one cycle per instruction, in its final state. RegWre and mWR never coincide with IF.

Decomposition:
- Shared package mc_defs:
  - opcode constants
  - state encodings
  - ALUOp codes
  - PCsrc codes (PC_NEXT, PC_BRANCH, PC_REG, PC_JUMP)
  - RegDst codes
- One sub-module, mc_output_decode: purely combinational (state, opcode, zero) -> control outputs. The top keeps the state register and the counter.

Test Plan:
- Reset held 2 cycles, then released with opcode=000000 -> state sequence 000,001,110,111,000. PCWre=1 only in WB_AL, with PCsrc=00, RegDst=10, RegWre=1. retired=1.
- beq (110100):
  - zero=1 -> EXE_BR gives PCsrc=01, PCWre=1.
  - zero=0 -> PCsrc=00.
  - Both cases: 3 cycles total, RegWre never 1.
- lw (110001) -> 5 states IF,ID,EXE_LS,MEM,WB_LD. mRD=1 in MEM and WB_LD; DBDataSrc=1 and RegWre=1 only in WB_LD. sw (110000) -> 4 states, mWR=1 in MEM only.
- jal (111010) -> ID gives PCsrc=11, RegWre=1, RegDst=00, WrRegData=0, PCWre=1; next state IF. jr (111001) -> PCsrc=10.
- halt (111111) for 10 cycles -> states alternate IF/ID, PCWre stays 0, retired is unchanged.
- Reset asserted while in MEM of sw -> no mWR on that edge; next state=IF, retired=0.
